wallace_mult_ctrl: RTL and testbench

//  Iterative multiplier sequencer built around a 5-operand Wallace/CSA reduction stage.
//  - Each iteration folds GROUP multiplier bits into the running accumulator.
//  - Adder operands per iteration: GROUP partial products plus the accumulator (5 total).
//  - Sits between the calculator operand/opcode decode and the result mux.
//  - Valid/ready handshakes on both the operand side and the result side.

---
 rtl/wallace_mult_ctrl_pkg.sv | 15 +
 rtl/wallace_mult_ctrl_csa.sv | 33 +++
 rtl/wallace_mult_ctrl.sv | 122 ++++++++++++
 tb/tb_wallace_mult_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/wallace_mult_ctrl_pkg.sv
// Shared definitions for the iterative Wallace-tree multiplier: FSM states and
// default operand geometry.
package wallace_mult_ctrl_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_GROUP = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_SIGN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/wallace_mult_ctrl_csa.sv
// Combinational 5-operand carry-save reduction (three 3:2 levels) followed by
// a single carry-propagate adder; all arithmetic is modulo 2^W.
module csa_5to1 #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] x0,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] x2,
  input  logic [W-1:0] x3,
  input  logic [W-1:0] x4,
  output logic [W-1:0] sum
);

  logic [W-1:0] s1, c1, s2, c2, s3, c3;
  logic [W-1:0] m1, m2, m3;

  always_comb begin
    s1 = x0 ^ x1 ^ x2;
    m1 = (x0 & x1) | (x0 & x2) | (x1 & x2);
    c1 = {m1[W-2:0], 1'b0};

    s2 = s1 ^ c1 ^ x3;
    m2 = (s1 & c1) | (s1 & x3) | (c1 & x3);
    c2 = {m2[W-2:0], 1'b0};

    s3 = s2 ^ c2 ^ x4;
    m3 = (s2 & c2) | (s2 & x4) | (c2 & x4);
    c3 = {m3[W-2:0], 1'b0};

    sum = s3 + c3;
  end

endmodule

// File: rtl/wallace_mult_ctrl.sv
// Iterative sign-magnitude multiplier: folds GROUP multiplier bits per cycle
// into an accumulator through a 5-input CSA tree, with valid/ready on both sides.
module wallace_mult_ctrl
  import wallace_mult_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned GROUP = DEF_GROUP
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 signed_op,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int unsigned N     = WIDTH / GROUP;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW    = 2 * WIDTH;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_mag, b_mag, a_abs, b_abs;
  logic               neg;
  logic [PW-1:0]      acc, sum, a_sh;
  logic [WIDTH-1:0]   b_grp;
  logic [31:0]        shamt;
  logic [PW-1:0]      pp [4];
  logic               accept, last_iter;

  assign accept    = in_valid & in_ready;
  assign last_iter = (cnt == CNT_W'(N - 1));

  always_comb begin
    a_abs = (signed_op & op_a[WIDTH-1]) ? -op_a : op_a;
    b_abs = (signed_op & op_b[WIDTH-1]) ? -op_b : op_b;
  end

  // Align the multiplicand and multiplier window once per iteration, then
  // each partial product only needs a further 0..3 bit shift.
  always_comb begin
    shamt = GROUP * 32'(cnt);
    a_sh  = {{WIDTH{1'b0}}, a_mag} << shamt;
    b_grp = b_mag >> shamt;
    for (int unsigned i = 0; i < 4; i++) begin
      pp[i] = b_grp[i] ? (a_sh << i) : '0;
    end
  end

  csa_5to1 #(.W(PW)) u_csa (
    .x0  (pp[0]),
    .x1  (pp[1]),
    .x2  (pp[2]),
    .x3  (pp[3]),
    .x4  (acc),
    .sum (sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ST_ITER;
      end
      ST_ITER: begin
        busy = 1'b1;
        if (last_iter) state_next = ST_SIGN;
      end
      ST_SIGN: begin
        busy       = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_next = in_valid ? ST_ITER : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_mag   <= '0;
      b_mag   <= '0;
      neg     <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      a_mag <= a_abs;
      b_mag <= b_abs;
      neg   <= signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_ITER: begin
          acc <= sum;
          cnt <= last_iter ? '0 : cnt + CNT_W'(1);
        end
        ST_SIGN: product <= neg ? -acc : acc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wallace_mult_ctrl.sv
// Directed self-checking bench for wallace_mult_ctrl at WIDTH=16.
module tb_wallace_mult_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        signed_op;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        busy;

  int checks = 0;
  int errors = 0;

  wallace_mult_ctrl #(.WIDTH(16), .GROUP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .signed_op (signed_op),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns just after the accepting edge.
  task automatic start_op(input string tag, input logic s, input logic [15:0] a,
                          input logic [15:0] b);
    int w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_in_ready"}, in_ready, 1);
    signed_op = s;
    op_a      = a;
    op_b      = b;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts edges from the accepting edge until out_valid; ends at a negedge.
  task automatic wait_result(input string tag, input logic [31:0] exp, input bit chk_lat);
    int lat = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (lat == 1) check({tag, "_busy"}, busy, 1);
    end while (!out_valid && lat < 20);
    check({tag, "_valid"}, out_valid, 1);
    if (chk_lat) check({tag, "_latency"}, lat, 5);
    check({tag, "_product"}, product, exp);
  endtask

  task automatic retire(input string tag, input logic [31:0] exp);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_retired"}, out_valid, 0);
    check({tag, "_kept"}, product, exp);
    check({tag, "_idle_ready"}, in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; signed_op = 1'b0;
    op_a = '0; op_b = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_product", product, 0);
    rst_n = 1'b1;
    @(negedge clk);

    start_op("u_small", 1'b0, 16'h03F5, 16'h000B);
    wait_result("u_small", 32'h0000_2B87, 1);
    retire("u_small", 32'h0000_2B87);

    start_op("s_m1m1", 1'b1, 16'hFFFF, 16'hFFFF);
    wait_result("s_m1m1", 32'h0000_0001, 1);
    retire("s_m1m1", 32'h0000_0001);

    start_op("u_max", 1'b0, 16'hFFFF, 16'hFFFF);
    wait_result("u_max", 32'hFFFE_0001, 1);
    retire("u_max", 32'hFFFE_0001);

    start_op("s_minmin", 1'b1, 16'h8000, 16'h8000);
    wait_result("s_minmin", 32'h4000_0000, 1);
    retire("s_minmin", 32'h4000_0000);

    start_op("s_min1", 1'b1, 16'h8000, 16'h0001);
    wait_result("s_min1", 32'hFFFF_8000, 1);
    retire("s_min1", 32'hFFFF_8000);

    start_op("s_m3x5", 1'b1, 16'hFFFD, 16'h0005);
    wait_result("s_m3x5", 32'hFFFF_FFF1, 1);
    retire("s_m3x5", 32'hFFFF_FFF1);

    start_op("s_maxmin", 1'b1, 16'h7FFF, 16'h8000);
    wait_result("s_maxmin", 32'hC000_8000, 1);
    retire("s_maxmin", 32'hC000_8000);

    // Held result, then accept-and-retire on the same edge.
    start_op("hold", 1'b0, 16'h1234, 16'h0010);
    wait_result("hold", 32'h0001_2340, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("hold%0d_valid", i), out_valid, 1);
      check($sformatf("hold%0d_product", i), product, 32'h0001_2340);
      check($sformatf("hold%0d_in_ready", i), in_ready, 0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    signed_op = 1'b0;
    op_a      = 16'h0000;
    op_b      = 16'h1234;
    #1 check("b2b_in_ready", in_ready, 1);
    @(posedge clk);
    #1 begin
      out_ready = 1'b0;
      in_valid  = 1'b0;
    end
    wait_result("b2b", 32'h0000_0000, 1);
    retire("b2b", 32'h0000_0000);

    // Operands offered while busy must be ignored.
    start_op("ign", 1'b0, 16'h0007, 16'h0006);
    @(negedge clk);
    signed_op = 1'b1;
    op_a      = 16'hFFFF;
    op_b      = 16'h8000;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_result("ign", 32'h0000_002A, 0);
    retire("ign", 32'h0000_002A);

    // Reset asserted during the second ITER cycle.
    start_op("abort", 1'b0, 16'h1234, 16'h5678);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_product", product, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_abort_valid", out_valid, 0);
    start_op("after", 1'b0, 16'h0007, 16'h0006);
    wait_result("after", 32'h0000_002A, 1);
    retire("after", 32'h0000_002A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
